// File: rtl/inst_fetcher_if.sv
// Fetch-stage signal bundle: PC unit, memory controller and instruction queue sides.
interface inst_fetcher_if;
  logic        ena;
  logic [31:0] in_pc;
  logic        in_pc_taken;
  logic        in_rollback;
  logic        out_pc_ena;
  logic [31:0] out_last_pc;
  logic [31:0] out_last_inst;
  logic        out_mem_req;
  logic [31:0] out_mem_addr;
  logic        in_mem_ready;
  logic [31:0] in_mem_data;
  logic        in_queue_full;
  logic        out_inst_valid;
  logic [31:0] out_inst;
  logic [31:0] out_inst_pc;
  logic        out_inst_taken;

  modport master (
    input  ena, in_pc, in_pc_taken, in_rollback, in_mem_ready, in_mem_data, in_queue_full,
    output out_pc_ena, out_last_pc, out_last_inst, out_mem_req, out_mem_addr,
           out_inst_valid, out_inst, out_inst_pc, out_inst_taken
  );

  modport slave (
    output ena, in_pc, in_pc_taken, in_rollback, in_mem_ready, in_mem_data, in_queue_full,
    input  out_pc_ena, out_last_pc, out_last_inst, out_mem_req, out_mem_addr,
           out_inst_valid, out_inst, out_inst_pc, out_inst_taken
  );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: direct-mapped I-cache looked up on in_pc, refilled word by word on a miss.
// state   | meaning
// FETCH   | look up in_pc; push on hit, issue refill on miss
// WAIT_PC | bubble while the PC unit samples out_pc_ena
// MISS    | refill outstanding
// DRAIN   | refill outstanding after a rollback; fill, then refetch
module inst_fetcher #(
  parameter int CACHE_INDEX_BITS = 6
) (
  input logic            clk,
  input logic            rst,
  inst_fetcher_if.master io_fetch
);
  localparam int ENTRIES  = 1 << CACHE_INDEX_BITS;
  localparam int TAG_BITS = 30 - CACHE_INDEX_BITS;

  typedef enum logic [1:0] {FETCH, WAIT_PC, MISS, DRAIN} state_t;

  state_t r_state, w_state_nxt;

  logic                r_inst_valid, r_pc_ena, r_inst_taken, r_mem_req;
  logic [31:0]         r_last_pc, r_last_inst, r_inst, r_inst_pc, r_mem_addr;
  logic [ENTRIES-1:0]  r_valid;
  logic [TAG_BITS-1:0] r_tag  [ENTRIES];
  logic [31:0]         r_data [ENTRIES];

  logic [CACHE_INDEX_BITS-1:0] w_idx, w_fill_idx;
  logic [TAG_BITS-1:0]         w_tag;
  logic                        w_hit, w_push, w_issue, w_fill, w_pc_ena_nxt;

  assign w_idx      = io_fetch.in_pc[CACHE_INDEX_BITS+1:2];
  assign w_tag      = io_fetch.in_pc[31:CACHE_INDEX_BITS+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill_idx = r_mem_addr[CACHE_INDEX_BITS+1:2];

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_state_nxt;
  end

  // Rollback outranks everything except a returning refill, which cannot be replayed.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_ena_nxt = 1'b0;
    w_push       = 1'b0;
    w_issue      = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      FETCH: begin
        if (!io_fetch.in_rollback && io_fetch.ena) begin
          if (w_hit) begin
            if (!io_fetch.in_queue_full) begin
              w_push       = 1'b1;
              w_pc_ena_nxt = 1'b1;
              w_state_nxt  = WAIT_PC;
            end
          end else begin
            w_issue     = 1'b1;
            w_state_nxt = MISS;
          end
        end
      end
      WAIT_PC: begin
        if (io_fetch.in_rollback) begin
          w_state_nxt = FETCH;
        end else if (io_fetch.ena) begin
          w_pc_ena_nxt = r_pc_ena;
          w_state_nxt  = FETCH;
        end
      end
      MISS: begin
        if (io_fetch.in_mem_ready) begin
          w_fill      = 1'b1;
          w_state_nxt = FETCH;
        end else if (io_fetch.in_rollback) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (io_fetch.in_mem_ready) begin
          w_fill      = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_valid <= 1'b0;
      r_pc_ena     <= 1'b0;
      r_inst_taken <= 1'b0;
      r_mem_req    <= 1'b0;
      r_last_pc    <= '0;
      r_last_inst  <= '0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_mem_addr   <= '0;
      r_valid      <= '0;
    end else begin
      r_inst_valid <= w_push;
      r_pc_ena     <= w_pc_ena_nxt;
      if (w_push) begin
        r_inst       <= r_data[w_idx];
        r_inst_pc    <= io_fetch.in_pc;
        r_inst_taken <= io_fetch.in_pc_taken;
        r_last_inst  <= r_data[w_idx];
        r_last_pc    <= io_fetch.in_pc;
      end
      if (w_issue) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= io_fetch.in_pc;
      end else if (w_fill) begin
        r_mem_req <= 1'b0;
      end
      if (w_fill) r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Data and tag arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= r_mem_addr[31:CACHE_INDEX_BITS+2];
      r_data[w_fill_idx] <= io_fetch.in_mem_data;
    end
  end

  assign io_fetch.out_inst_valid = r_inst_valid;
  assign io_fetch.out_inst       = r_inst;
  assign io_fetch.out_inst_pc    = r_inst_pc;
  assign io_fetch.out_inst_taken = r_inst_taken;
  assign io_fetch.out_pc_ena     = r_pc_ena;
  assign io_fetch.out_last_pc    = r_last_pc;
  assign io_fetch.out_last_inst  = r_last_inst;
  assign io_fetch.out_mem_req    = r_mem_req;
  assign io_fetch.out_mem_addr   = r_mem_addr;
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed scenarios plus a random fetch stream against a word-address cache model.
module tb_inst_fetcher;
  localparam int LINES = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetcher_if f ();
  inst_fetcher #(.CACHE_INDEX_BITS(6)) dut (.clk(clk), .rst(rst), .io_fetch(f));

  int n_cmp = 0;
  int n_bad = 0;
  int n_req = 0;

  // Model: memory image plus, per cache line, the full word address it currently holds.
  logic [31:0] mem_img [logic [31:0]];
  bit          m_valid [LINES];
  logic [31:0] m_addr  [LINES];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic get_word(input logic [31:0] a, output logic [31:0] w);
    if (!mem_img.exists(a)) mem_img[a] = $urandom;
    w = mem_img[a];
  endtask

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % LINES);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[slot_of(pc)] && (m_addr[slot_of(pc)] == pc);
  endfunction

  task automatic model_fill(input logic [31:0] pc);
    m_valid[slot_of(pc)] = 1'b1;
    m_addr[slot_of(pc)]  = pc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    f.ena = 1'b1; f.in_pc = '0; f.in_pc_taken = 1'b0; f.in_rollback = 1'b0;
    f.in_mem_ready = 1'b0; f.in_mem_data = '0; f.in_queue_full = 1'b0;
    repeat (2) tick();
    chk1("rst_valid", f.out_inst_valid, 1'b0);
    chk1("rst_pc_ena", f.out_pc_ena, 1'b0);
    chk1("rst_req", f.out_mem_req, 1'b0);
    chk32("rst_addr", f.out_mem_addr, 32'h0);
    chk32("rst_inst", f.out_inst, 32'h0);
    chk32("rst_inst_pc", f.out_inst_pc, 32'h0);
    chk1("rst_taken", f.out_inst_taken, 1'b0);
    chk32("rst_last_pc", f.out_last_pc, 32'h0);
    chk32("rst_last_inst", f.out_last_inst, 32'h0);
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    rst = 1'b0;
  endtask

  // Push edge, then the bubble cycle in which out_pc_ena is still high.
  task automatic expect_push(input logic [31:0] pc, input logic [31:0] w, input logic tk);
    tick();
    chk1("push_valid", f.out_inst_valid, 1'b1);
    chk32("push_inst", f.out_inst, w);
    chk32("push_pc", f.out_inst_pc, pc);
    chk1("push_taken", f.out_inst_taken, tk);
    chk1("push_pc_ena", f.out_pc_ena, 1'b1);
    chk32("push_last_pc", f.out_last_pc, pc);
    chk32("push_last_inst", f.out_last_inst, w);
    chk1("push_no_req", f.out_mem_req, 1'b0);
    tick();
    chk1("bubble_valid", f.out_inst_valid, 1'b0);
    chk1("bubble_pc_ena", f.out_pc_ena, 1'b1);
  endtask

  // Memory answers on cycle 1+lat after the request appears.
  task automatic refill(input logic [31:0] pc, input int lat);
    logic [31:0] w;
    get_word(pc, w);
    tick();
    chk1("miss_req", f.out_mem_req, 1'b1);
    chk32("miss_addr", f.out_mem_addr, pc);
    chk1("miss_valid", f.out_inst_valid, 1'b0);
    if (f.out_mem_req === 1'b1) n_req++;
    for (int i = 0; i < lat; i++) begin
      tick();
      chk1("miss_hold_req", f.out_mem_req, 1'b1);
      chk32("miss_hold_addr", f.out_mem_addr, pc);
    end
    f.in_mem_ready = 1'b1;
    f.in_mem_data  = w;
    tick();
    f.in_mem_ready = 1'b0;
    f.in_mem_data  = $urandom;
    chk1("fill_req_drop", f.out_mem_req, 1'b0);
    chk1("fill_valid", f.out_inst_valid, 1'b0);
    model_fill(pc);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic tk, input int lat, input int qf);
    logic [31:0] w;
    get_word(pc, w);
    f.in_pc = pc;
    f.in_pc_taken = tk;
    if (model_hit(pc)) begin
      if (qf > 0) begin
        f.in_queue_full = 1'b1;
        repeat (qf) begin
          tick();
          chk1("qfull_valid", f.out_inst_valid, 1'b0);
          chk1("qfull_pc_ena", f.out_pc_ena, 1'b0);
          chk1("qfull_req", f.out_mem_req, 1'b0);
        end
        f.in_queue_full = 1'b0;
      end
    end else begin
      refill(pc, lat);
    end
    expect_push(pc, w, tk);
  endtask

  initial begin
    logic [31:0] w;
    int          saved;
    mem_img[32'h0] = 32'h00500093;
    do_reset();

    // Cold miss at 0x0, memory answers on cycle 5; push on cycle 7.
    fetch(32'h0, 1'b0, 4, 0);

    // Fill 0x4/0x8, then a pure hit stream with no requests.
    fetch(32'h4, 1'b1, 1, 0);
    fetch(32'h8, 1'b0, 0, 0);
    saved = n_req;
    fetch(32'h0, 1'b0, 0, 0);
    fetch(32'h4, 1'b1, 0, 0);
    fetch(32'h8, 1'b0, 0, 0);
    chk32("stream_no_req", n_req, saved);

    // Hit held off by a full queue for 4 cycles.
    fetch(32'h4, 1'b0, 0, 4);

    // Rollback coinciding with a hit: nothing pushed, corrected PC follows.
    f.in_pc = 32'h8;
    f.in_rollback = 1'b1;
    tick();
    f.in_rollback = 1'b0;
    chk1("rb_hit_valid", f.out_inst_valid, 1'b0);
    chk1("rb_hit_pc_ena", f.out_pc_ena, 1'b0);
    fetch(32'h0, 1'b1, 0, 0);

    // Rollback while the 0x40 refill is outstanding.
    f.in_pc = 32'h40;
    tick();
    chk1("rbm_req", f.out_mem_req, 1'b1);
    chk32("rbm_addr", f.out_mem_addr, 32'h40);
    n_req++;
    f.in_rollback = 1'b1;
    tick();
    f.in_rollback = 1'b0;
    f.in_pc = 32'h100;
    chk1("drain_req", f.out_mem_req, 1'b1);
    repeat (2) begin
      tick();
      chk1("drain_hold_req", f.out_mem_req, 1'b1);
      chk32("drain_hold_addr", f.out_mem_addr, 32'h40);
      chk1("drain_valid", f.out_inst_valid, 1'b0);
    end
    f.in_rollback = 1'b1;
    tick();
    f.in_rollback = 1'b0;
    chk1("drain_rb_req", f.out_mem_req, 1'b1);
    get_word(32'h40, w);
    f.in_mem_ready = 1'b1;
    f.in_mem_data = w;
    tick();
    f.in_mem_ready = 1'b0;
    chk1("drain_fill_req", f.out_mem_req, 1'b0);
    chk1("drain_fill_valid", f.out_inst_valid, 1'b0);
    model_fill(32'h40);
    fetch(32'h100, 1'b0, 1, 0);
    saved = n_req;
    fetch(32'h40, 1'b1, 0, 0);
    chk32("drain_fill_hit", n_req, saved);

    // Refill returns while ena is low; frozen afterwards until ena rises.
    f.in_pc = 32'h3000;
    f.in_pc_taken = 1'b1;
    tick();
    chk1("ena_req", f.out_mem_req, 1'b1);
    n_req++;
    f.ena = 1'b0;
    tick();
    chk1("ena_hold_req", f.out_mem_req, 1'b1);
    get_word(32'h3000, w);
    f.in_mem_ready = 1'b1;
    f.in_mem_data = w;
    tick();
    f.in_mem_ready = 1'b0;
    chk1("ena_fill_req", f.out_mem_req, 1'b0);
    model_fill(32'h3000);
    repeat (2) begin
      tick();
      chk1("ena_low_valid", f.out_inst_valid, 1'b0);
      chk1("ena_low_pc_ena", f.out_pc_ena, 1'b0);
      chk1("ena_low_req", f.out_mem_req, 1'b0);
    end
    f.ena = 1'b1;
    expect_push(32'h3000, w, 1'b1);

    // Conflict eviction from a clean cache: 0x0, 0x100, 0x0 all miss.
    do_reset();
    saved = n_req;
    fetch(32'h0, 1'b0, 2, 0);
    fetch(32'h100, 1'b0, 1, 0);
    fetch(32'h0, 1'b0, 3, 0);
    chk32("conflict_reqs", n_req - saved, 32'd3);

    // Random stream over a small address window to force reuse and conflicts.
    for (int k = 0; k < 60; k++) begin
      logic [31:0] pc;
      int          qf;
      pc = 32'($urandom_range(0, 127)) * 32'd4;
      qf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      fetch(pc, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), qf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
